// File: rtl/axi_latency_pmu.sv
// Passive AXI latency monitor. Never drives the bus. Shadow readout on data_o is valid
// one cycle after snapshot_i. The monitor applies no backpressure to the monitored link.
module axi_latency_pmu_dir #(
  parameter int CNT_WIDTH = 48,
  parameter int TS_WIDTH  = 16,
  parameter int DEPTH     = 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [TS_WIDTH-1:0]    ts_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   enable_i,
  input  logic                   clear_i,
  output logic [CNT_WIDTH-1:0]   count_o,
  output logic [CNT_WIDTH-1:0]   sum_o,
  output logic [TS_WIDTH-1:0]    min_o,
  output logic [TS_WIDTH-1:0]    max_o,
  output logic [CNT_WIDTH-1:0]   orphan_o,
  output logic [$clog2(DEPTH):0] occ_o,
  output logic                   ovf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = DEPTH[AW:0];

  logic [TS_WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]          occ_q, occ_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] count_q, count_d, sum_q, sum_d, orphan_q, orphan_d;
  logic [TS_WIDTH-1:0]  min_q, min_d, max_q, max_d;
  logic                 empty, full, pop_hit, push_ok;
  logic [TS_WIDTH-1:0]  lat;
  logic [CNT_WIDTH:0]   sum_ext;

  // A pop against a full FIFO frees the slot the same-cycle push needs.
  assign empty   = (occ_q == '0);
  assign full    = (occ_q == FULL_OCC);
  assign pop_hit = pop_i && !empty;
  assign push_ok = push_i && (!full || pop_hit);
  assign lat     = ts_i - mem_q[rptr_q];
  assign sum_ext = {1'b0, sum_q} + {{(CNT_WIDTH + 1 - TS_WIDTH){1'b0}}, lat};

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    ovf_d  = ovf_q | (push_i && full && !pop_hit);
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_hit) rptr_d = rptr_q + AW'(1);
    if (push_ok && !pop_hit) occ_d = occ_q + (AW + 1)'(1);
    else if (!push_ok && pop_hit) occ_d = occ_q - (AW + 1)'(1);
  end

  always_comb begin
    count_d  = count_q;
    sum_d    = sum_q;
    min_d    = min_q;
    max_d    = max_q;
    orphan_d = orphan_q;
    if (clear_i) begin
      count_d  = '0;
      sum_d    = '0;
      min_d    = '1;
      max_d    = '0;
      orphan_d = '0;
    end else if (enable_i && pop_hit) begin
      if (count_q != '1) count_d = count_q + CNT_WIDTH'(1);
      sum_d = sum_ext[CNT_WIDTH] ? '1 : sum_ext[CNT_WIDTH-1:0];
      if (lat < min_q) min_d = lat;
      if (lat > max_q) max_d = lat;
    end else if (enable_i && pop_i && (orphan_q != '1)) begin
      orphan_d = orphan_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      sum_q    <= '0;
      min_q    <= '1;
      max_q    <= '0;
      orphan_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      min_q    <= min_d;
      max_q    <= max_d;
      orphan_q <= orphan_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push_ok) mem_q[wptr_q] <= ts_i;
  end

  assign count_o  = count_q;
  assign sum_o    = sum_q;
  assign min_o    = min_q;
  assign max_o    = max_q;
  assign orphan_o = orphan_q;
  assign occ_o    = occ_q;
  assign ovf_o    = ovf_q;
endmodule

module axi_latency_pmu #(
  parameter int CNT_WIDTH = 48,
  parameter int TS_WIDTH  = 16,
  parameter int RD_DEPTH  = 8,
  parameter int WR_DEPTH  = 8
) (
  input  logic        aclk,
  input  logic        aresetn,
  // {BREADY, AWVALID, RREADY, ARVALID}
  input  logic [3:0]  mon_axi_mosi,
  // {BVALID, AWREADY, RLAST, RVALID, ARREADY}
  input  logic [4:0]  mon_axi_miso,
  input  logic        enable_i,
  input  logic        clear_i,
  input  logic        snapshot_i,
  input  logic [4:0]  addr_i,
  output logic [63:0] data_o
);
  localparam int RD_OW = $clog2(RD_DEPTH) + 1;
  localparam int WR_OW = $clog2(WR_DEPTH) + 1;

  logic [TS_WIDTH-1:0]  ts_q;
  logic [63:0]          cycle_q, cycle_s_q;
  logic                 rd_push, rd_pop, wr_push, wr_pop;
  logic [CNT_WIDTH-1:0] rd_count, rd_sum, rd_orphan, wr_count, wr_sum, wr_orphan;
  logic [TS_WIDTH-1:0]  rd_min, rd_max, wr_min, wr_max;
  logic [RD_OW-1:0]     rd_occ;
  logic [WR_OW-1:0]     wr_occ;
  logic                 rd_ovf, wr_ovf;

  logic [CNT_WIDTH-1:0] rd_count_s_q, rd_sum_s_q, rd_orphan_s_q;
  logic [CNT_WIDTH-1:0] wr_count_s_q, wr_sum_s_q, wr_orphan_s_q;
  logic [TS_WIDTH-1:0]  rd_min_s_q, rd_max_s_q, wr_min_s_q, wr_max_s_q;
  logic [RD_OW-1:0]     rd_occ_s_q;
  logic [WR_OW-1:0]     wr_occ_s_q;
  logic                 rd_ovf_s_q, wr_ovf_s_q;

  assign rd_push = mon_axi_mosi[0] && mon_axi_miso[0];
  assign rd_pop  = mon_axi_miso[1] && mon_axi_mosi[1] && mon_axi_miso[2];
  assign wr_push = mon_axi_mosi[2] && mon_axi_miso[3];
  assign wr_pop  = mon_axi_miso[4] && mon_axi_mosi[3];

  axi_latency_pmu_dir #(.CNT_WIDTH(CNT_WIDTH), .TS_WIDTH(TS_WIDTH), .DEPTH(RD_DEPTH)) u_rd (
    .aclk(aclk), .aresetn(aresetn), .ts_i(ts_q), .push_i(rd_push), .pop_i(rd_pop),
    .enable_i(enable_i), .clear_i(clear_i), .count_o(rd_count), .sum_o(rd_sum),
    .min_o(rd_min), .max_o(rd_max), .orphan_o(rd_orphan), .occ_o(rd_occ), .ovf_o(rd_ovf)
  );

  axi_latency_pmu_dir #(.CNT_WIDTH(CNT_WIDTH), .TS_WIDTH(TS_WIDTH), .DEPTH(WR_DEPTH)) u_wr (
    .aclk(aclk), .aresetn(aresetn), .ts_i(ts_q), .push_i(wr_push), .pop_i(wr_pop),
    .enable_i(enable_i), .clear_i(clear_i), .count_o(wr_count), .sum_o(wr_sum),
    .min_o(wr_min), .max_o(wr_max), .orphan_o(wr_orphan), .occ_o(wr_occ), .ovf_o(wr_ovf)
  );

  // Shadow bank samples the live registers before this edge's update, so a
  // snapshot coinciding with clear_i captures the pre-clear values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ts_q          <= '0;
      cycle_q       <= '0;
      cycle_s_q     <= '0;
      rd_count_s_q  <= '0;
      rd_sum_s_q    <= '0;
      rd_min_s_q    <= '1;
      rd_max_s_q    <= '0;
      rd_orphan_s_q <= '0;
      rd_occ_s_q    <= '0;
      rd_ovf_s_q    <= 1'b0;
      wr_count_s_q  <= '0;
      wr_sum_s_q    <= '0;
      wr_min_s_q    <= '1;
      wr_max_s_q    <= '0;
      wr_orphan_s_q <= '0;
      wr_occ_s_q    <= '0;
      wr_ovf_s_q    <= 1'b0;
    end else begin
      ts_q    <= ts_q + TS_WIDTH'(1);
      cycle_q <= cycle_q + 64'd1;
      if (snapshot_i) begin
        cycle_s_q     <= cycle_q;
        rd_count_s_q  <= rd_count;
        rd_sum_s_q    <= rd_sum;
        rd_min_s_q    <= rd_min;
        rd_max_s_q    <= rd_max;
        rd_orphan_s_q <= rd_orphan;
        rd_occ_s_q    <= rd_occ;
        rd_ovf_s_q    <= rd_ovf;
        wr_count_s_q  <= wr_count;
        wr_sum_s_q    <= wr_sum;
        wr_min_s_q    <= wr_min;
        wr_max_s_q    <= wr_max;
        wr_orphan_s_q <= wr_orphan;
        wr_occ_s_q    <= wr_occ;
        wr_ovf_s_q    <= wr_ovf;
      end
    end
  end

  always_comb begin
    data_o = '0;
    case (addr_i)
      5'd0:    data_o = 64'(rd_count_s_q);
      5'd1:    data_o = 64'(rd_sum_s_q);
      5'd2:    data_o = 64'(rd_min_s_q);
      5'd3:    data_o = 64'(rd_max_s_q);
      5'd4:    data_o = 64'(rd_orphan_s_q);
      5'd5:    data_o = 64'(rd_occ_s_q);
      5'd6:    data_o = 64'(wr_count_s_q);
      5'd7:    data_o = 64'(wr_sum_s_q);
      5'd8:    data_o = 64'(wr_min_s_q);
      5'd9:    data_o = 64'(wr_max_s_q);
      5'd10:   data_o = 64'(wr_orphan_s_q);
      5'd11:   data_o = 64'(wr_occ_s_q);
      5'd12:   data_o = {62'b0, wr_ovf_s_q, rd_ovf_s_q};
      5'd13:   data_o = cycle_s_q;
      default: data_o = '0;
    endcase
  end
endmodule

// File: tb/tb_axi_latency_pmu.sv
// Bench for axi_latency_pmu: directed scenarios plus random traffic against a queue-based model.
module tb_axi_latency_pmu;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        arvalid = 0, arready = 0, rvalid = 0, rready = 0, rlast = 0;
  logic        awvalid = 0, awready = 0, bvalid = 0, bready = 0;
  logic        enable_i = 1'b1, clear_i = 1'b0, snapshot_i = 1'b0;
  logic [4:0]  addr_i = '0;
  logic [63:0] data_o;
  logic [3:0]  mon_axi_mosi;
  logic [4:0]  mon_axi_miso;

  assign mon_axi_mosi = {bready, awvalid, rready, arvalid};
  assign mon_axi_miso = {bvalid, awready, rlast, rvalid, arready};

  axi_latency_pmu dut (
    .aclk(aclk), .aresetn(aresetn), .mon_axi_mosi(mon_axi_mosi), .mon_axi_miso(mon_axi_miso),
    .enable_i(enable_i), .clear_i(clear_i), .snapshot_i(snapshot_i), .addr_i(addr_i),
    .data_o(data_o)
  );

  always #50 aclk = ~aclk;

  localparam longint CNT_MAX = 64'h0000_FFFF_FFFF_FFFF;
  int     checks = 0;
  int     errors = 0;
  longint m_ts, m_cycle;
  int     q_rd[$];
  int     q_wr[$];
  longint m_count[2], m_sum[2], m_min[2], m_max[2], m_orph[2];
  bit     m_ovf[2];
  longint s_val[14];

  function automatic longint live_val(int a);
    case (a)
      0: return m_count[0];  1: return m_sum[0];  2: return m_min[0];
      3: return m_max[0];    4: return m_orph[0]; 5: return longint'(q_rd.size());
      6: return m_count[1];  7: return m_sum[1];  8: return m_min[1];
      9: return m_max[1];   10: return m_orph[1]; 11: return longint'(q_wr.size());
      12: return longint'(m_ovf[1]) * 2 + longint'(m_ovf[0]);
      13: return m_cycle;
      default: return 0;
    endcase
  endfunction

  function automatic longint exp_val(int a);
    return (a < 14) ? s_val[a] : 0;
  endfunction

  task automatic model_dir(int d, bit push, bit pop);
    int     head;
    longint lat;
    int     sz;
    sz = (d == 0) ? q_rd.size() : q_wr.size();
    if (pop) begin
      if (sz > 0) begin
        if (d == 0) head = q_rd.pop_front();
        else        head = q_wr.pop_front();
        lat = (m_ts - head + 65536) % 65536;
        if (enable_i) begin
          if (m_count[d] < CNT_MAX) m_count[d]++;
          m_sum[d] = (m_sum[d] + lat > CNT_MAX) ? CNT_MAX : m_sum[d] + lat;
          if (lat < m_min[d]) m_min[d] = lat;
          if (lat > m_max[d]) m_max[d] = lat;
        end
      end else if (enable_i && m_orph[d] < CNT_MAX) begin
        m_orph[d]++;
      end
    end
    sz = (d == 0) ? q_rd.size() : q_wr.size();
    if (push) begin
      if (sz < 8) begin
        if (d == 0) q_rd.push_back(int'(m_ts));
        else        q_wr.push_back(int'(m_ts));
      end else begin
        m_ovf[d] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    bit rpu, rp, wpu, wp;
    rpu = arvalid && arready;
    rp  = rvalid && rready && rlast;
    wpu = awvalid && awready;
    wp  = bvalid && bready;
    if (snapshot_i) for (int a = 0; a < 14; a++) s_val[a] = live_val(a);
    model_dir(0, rpu, rp);
    model_dir(1, wpu, wp);
    if (clear_i) begin
      for (int d = 0; d < 2; d++) begin
        m_count[d] = 0; m_sum[d] = 0; m_orph[d] = 0; m_max[d] = 0; m_min[d] = 65535;
      end
    end
    m_ts = (m_ts + 1) % 65536;
    m_cycle++;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    arvalid = 0; arready = 0; rvalid = 0; rready = 0; rlast = 0;
    awvalid = 0; awready = 0; bvalid = 0; bready = 0;
    clear_i = 0; snapshot_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    enable_i = 1'b1;
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    m_ts = 0; m_cycle = 0;
    q_rd.delete(); q_wr.delete();
    for (int d = 0; d < 2; d++) begin
      m_count[d] = 0; m_sum[d] = 0; m_orph[d] = 0; m_max[d] = 0; m_min[d] = 65535; m_ovf[d] = 0;
    end
    for (int a = 0; a < 14; a++) s_val[a] = 0;
    s_val[2] = 65535;
    s_val[8] = 65535;
    aresetn = 1'b1;
  endtask

  task automatic snap();
    snapshot_i = 1'b1;
    tick();
    snapshot_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    snap();
    addr_i = 5'd0; #1; checks++;
    if (data_o !== 64'd0) begin errors++; $display("FAIL reset_rd_count got %0h exp 0", data_o); end
    addr_i = 5'd2; #1; checks++;
    if (data_o !== 64'hFFFF) begin errors++; $display("FAIL reset_rd_min got %0h exp ffff", data_o); end
    addr_i = 5'd8; #1; checks++;
    if (data_o !== 64'hFFFF) begin errors++; $display("FAIL reset_wr_min got %0h exp ffff", data_o); end
    addr_i = 5'd12; #1; checks++;
    if (data_o !== 64'd0) begin errors++; $display("FAIL reset_status got %0h exp 0", data_o); end
    for (int a = 0; a < 32; a++) begin
      addr_i = 5'(a); #1; checks++;
      if (data_o !== 64'(exp_val(a))) begin
        errors++; $display("FAIL reset_map addr %0d got %0h exp %0h", a, data_o, exp_val(a));
      end
    end
  endtask

  task automatic test_single_read();
    do_reset();
    while (m_ts < 10) tick();
    arvalid = 1; arready = 1; tick(); arvalid = 0; arready = 0;
    while (m_ts < 14) tick();
    rvalid = 1; rready = 1; rlast = 0; tick(); rvalid = 0; rready = 0;
    while (m_ts < 17) tick();
    rvalid = 1; rready = 1; rlast = 1; tick(); rvalid = 0; rready = 0; rlast = 0;
    snap();
    addr_i = 5'd0; #1; checks++;
    if (data_o !== 64'd1) begin errors++; $display("FAIL single_rd_count got %0d exp 1", data_o); end
    addr_i = 5'd1; #1; checks++;
    if (data_o !== 64'd7) begin errors++; $display("FAIL single_rd_sum got %0d exp 7", data_o); end
    addr_i = 5'd2; #1; checks++;
    if (data_o !== 64'd7) begin errors++; $display("FAIL single_rd_min got %0d exp 7", data_o); end
    addr_i = 5'd3; #1; checks++;
    if (data_o !== 64'd7) begin errors++; $display("FAIL single_rd_max got %0d exp 7", data_o); end
    for (int a = 0; a < 32; a++) begin
      addr_i = 5'(a); #1; checks++;
      if (data_o !== 64'(exp_val(a))) begin
        errors++; $display("FAIL single_map addr %0d got %0h exp %0h", a, data_o, exp_val(a));
      end
    end
  endtask

  task automatic test_back_to_back();
    longint t0;
    do_reset();
    tick(); tick(); tick();
    t0 = m_ts;
    awvalid = 1; awready = 1;
    tick(); tick(); tick();
    awvalid = 0; awready = 0;
    while (m_ts < t0 + 4) tick();
    bvalid = 1; bready = 1; tick(); bvalid = 0; bready = 0;
    while (m_ts < t0 + 7) tick();
    bvalid = 1; bready = 1; tick(); bvalid = 0; bready = 0;
    while (m_ts < t0 + 9) tick();
    bvalid = 1; bready = 0; tick(); bvalid = 0;
    while (m_ts < t0 + 11) tick();
    bvalid = 1; bready = 1; tick(); bvalid = 0; bready = 0;
    snap();
    addr_i = 5'd6; #1; checks++;
    if (data_o !== 64'd3) begin errors++; $display("FAIL b2b_wr_count got %0d exp 3", data_o); end
    addr_i = 5'd7; #1; checks++;
    if (data_o !== 64'd19) begin errors++; $display("FAIL b2b_wr_sum got %0d exp 19", data_o); end
    addr_i = 5'd8; #1; checks++;
    if (data_o !== 64'd4) begin errors++; $display("FAIL b2b_wr_min got %0d exp 4", data_o); end
    addr_i = 5'd9; #1; checks++;
    if (data_o !== 64'd9) begin errors++; $display("FAIL b2b_wr_max got %0d exp 9", data_o); end
    addr_i = 5'd11; #1; checks++;
    if (data_o !== 64'd0) begin errors++; $display("FAIL b2b_wr_occ got %0d exp 0", data_o); end
    for (int a = 0; a < 32; a++) begin
      addr_i = 5'(a); #1; checks++;
      if (data_o !== 64'(exp_val(a))) begin
        errors++; $display("FAIL b2b_map addr %0d got %0h exp %0h", a, data_o, exp_val(a));
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    arvalid = 1; arready = 1;
    for (int i = 0; i < 9; i++) tick();
    arvalid = 0; arready = 0;
    snap();
    addr_i = 5'd5; #1; checks++;
    if (data_o !== 64'd8) begin errors++; $display("FAIL ovf_rd_occ got %0d exp 8", data_o); end
    addr_i = 5'd12; #1; checks++;
    if (data_o !== 64'd1) begin errors++; $display("FAIL ovf_status got %0d exp 1", data_o); end
    clear_i = 1; tick(); clear_i = 0;
    // Full FIFO with simultaneous push and pop: occupancy must hold at 8.
    arvalid = 1; arready = 1; rvalid = 1; rready = 1; rlast = 1; tick(); idle_inputs();
    snap();
    addr_i = 5'd12; #1; checks++;
    if (data_o !== 64'd1) begin errors++; $display("FAIL ovf_after_clear got %0d exp 1", data_o); end
    addr_i = 5'd5; #1; checks++;
    if (data_o !== 64'd8) begin errors++; $display("FAIL ovf_pushpop_occ got %0d exp 8", data_o); end
    for (int a = 0; a < 32; a++) begin
      addr_i = 5'(a); #1; checks++;
      if (data_o !== 64'(exp_val(a))) begin
        errors++; $display("FAIL ovf_map addr %0d got %0h exp %0h", a, data_o, exp_val(a));
      end
    end
  endtask

  task automatic test_orphan();
    do_reset();
    tick();
    bvalid = 1; bready = 1; tick(); bvalid = 0; bready = 0;
    snap();
    addr_i = 5'd10; #1; checks++;
    if (data_o !== 64'd1) begin errors++; $display("FAIL orphan_count got %0d exp 1", data_o); end
    addr_i = 5'd6; #1; checks++;
    if (data_o !== 64'd0) begin errors++; $display("FAIL orphan_wr_count got %0d exp 0", data_o); end
    enable_i = 0;
    awvalid = 1; awready = 1; tick(); awvalid = 0; awready = 0;
    tick();
    bvalid = 1; bready = 1; tick(); tick(); bvalid = 0; bready = 0;
    snap();
    enable_i = 1;
    addr_i = 5'd10; #1; checks++;
    if (data_o !== 64'd1) begin errors++; $display("FAIL orphan_disabled got %0d exp 1", data_o); end
    addr_i = 5'd11; #1; checks++;
    if (data_o !== 64'd0) begin errors++; $display("FAIL orphan_disabled_pop got %0d exp 0", data_o); end
    for (int a = 0; a < 32; a++) begin
      addr_i = 5'(a); #1; checks++;
      if (data_o !== 64'(exp_val(a))) begin
        errors++; $display("FAIL orphan_map addr %0d got %0h exp %0h", a, data_o, exp_val(a));
      end
    end
  endtask

  task automatic test_clear_snapshot();
    do_reset();
    arvalid = 1; arready = 1; tick(); arvalid = 0; arready = 0;
    tick();
    arvalid = 1; arready = 1; tick(); arvalid = 0; arready = 0;
    tick(); tick();
    rvalid = 1; rready = 1; rlast = 1; tick(); idle_inputs();
    tick();
    rvalid = 1; rready = 1; rlast = 1; clear_i = 1; snapshot_i = 1; tick(); idle_inputs();
    addr_i = 5'd0; #1; checks++;
    if (data_o !== 64'd1) begin errors++; $display("FAIL clrsnap_count got %0d exp 1", data_o); end
    addr_i = 5'd2; #1; checks++;
    if (data_o !== 64'd5) begin errors++; $display("FAIL clrsnap_min got %0d exp 5", data_o); end
    addr_i = 5'd5; #1; checks++;
    if (data_o !== 64'd1) begin errors++; $display("FAIL clrsnap_occ got %0d exp 1", data_o); end
    snap();
    addr_i = 5'd0; #1; checks++;
    if (data_o !== 64'd0) begin errors++; $display("FAIL postclr_count got %0d exp 0", data_o); end
    addr_i = 5'd2; #1; checks++;
    if (data_o !== 64'hFFFF) begin errors++; $display("FAIL postclr_min got %0h exp ffff", data_o); end
    addr_i = 5'd5; #1; checks++;
    if (data_o !== 64'd0) begin errors++; $display("FAIL postclr_occ got %0d exp 0", data_o); end
    for (int a = 0; a < 32; a++) begin
      addr_i = 5'(a); #1; checks++;
      if (data_o !== 64'(exp_val(a))) begin
        errors++; $display("FAIL clrsnap_map addr %0d got %0h exp %0h", a, data_o, exp_val(a));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    arvalid = 1; arready = 1; tick(); tick(); arvalid = 0; arready = 0;
    do_reset();
    tick();
    rvalid = 1; rready = 1; rlast = 1; tick(); idle_inputs();
    snap();
    addr_i = 5'd4; #1; checks++;
    if (data_o !== 64'd1) begin errors++; $display("FAIL midrst_orphan got %0d exp 1", data_o); end
    addr_i = 5'd0; #1; checks++;
    if (data_o !== 64'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", data_o); end
    addr_i = 5'd5; #1; checks++;
    if (data_o !== 64'd0) begin errors++; $display("FAIL midrst_occ got %0d exp 0", data_o); end
  endtask

  task automatic test_random();
    bit snapped;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      arvalid  = ($urandom_range(3) == 0);
      arready  = ($urandom_range(1) == 0);
      rvalid   = ($urandom_range(2) == 0);
      rready   = ($urandom_range(3) != 0);
      rlast    = ($urandom_range(1) == 0);
      awvalid  = ($urandom_range(3) == 0);
      awready  = ($urandom_range(1) == 0);
      bvalid   = ($urandom_range(2) == 0);
      bready   = ($urandom_range(3) != 0);
      enable_i = ($urandom_range(9) != 0);
      clear_i  = ($urandom_range(49) == 0);
      snapped  = ($urandom_range(9) == 0);
      snapshot_i = snapped;
      tick();
      if (snapped) begin
        for (int a = 0; a < 32; a++) begin
          addr_i = 5'(a); #1; checks++;
          if (data_o !== 64'(exp_val(a))) begin
            errors++; $display("FAIL random_map cyc %0d addr %0d got %0h exp %0h", i, a, data_o, exp_val(a));
          end
        end
      end
    end
    idle_inputs();
    enable_i = 1;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_overflow();
    test_orphan();
    test_clear_snapshot();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
